// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus IF/ID pipeline register.
//
// Issues fetches over a req/gnt/rvalid handshake with at most one request
// outstanding, steers the fetch PC on EX-stage redirects, and keeps a
// one-entry buffer so a response arriving while decode is stalled is kept.
//
// State table:
//   S_REQ  | no request outstanding, request at PCF when allowed
//   S_WAIT | one request outstanding, waiting for imem_rvalid
//   S_HOLD | response captured in hold buffer, waiting for StallD to drop
//
// Ports:
//   clk, reset (async, active low)
//   StallF, StallD, FlushD         - hazard unit controls
//   PCSrcE, PCJalSrcE              - EX redirect and target select
//   PCTargetE, ALUResultE          - EX redirect targets
//   imem_req/addr/gnt/rvalid/rdata - instruction memory handshake
//   InstrD, PCD, PCPlus4D, ValidD  - IF/ID register outputs
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic            PCJalSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] ALUResultE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pcf, req_pc, buf_instr, buf_pc, redirect_pc;
  logic            kill;
  logic            rsp, rsp_live, grant, load_mem, load_buf, capture;

  // Responses only count while a request is outstanding; anything else
  // (e.g. a late response from before a reset) is ignored.
  assign rsp         = (state == S_WAIT) & imem_rvalid;
  assign rsp_live    = rsp & ~kill;
  assign grant       = imem_req & imem_gnt;
  assign redirect_pc = PCJalSrcE ? {ALUResultE[XLEN-1:1], 1'b0} : PCTargetE;
  assign imem_addr   = pcf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_REQ;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:  if (grant) state_nxt = S_WAIT;
      S_WAIT: begin
        if (rsp) begin
          if (kill || PCSrcE) state_nxt = S_REQ;
          else if (StallD)    state_nxt = S_HOLD;
          else                state_nxt = grant ? S_WAIT : S_REQ;
        end
      end
      S_HOLD: if (PCSrcE || !StallD) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  // The rvalid -> req path lets a zero-wait memory sustain one fetch per cycle.
  always_comb begin
    imem_req = reset & ~StallF & ~PCSrcE &
               ((state == S_REQ) | (rsp_live & ~StallD));
    load_mem = rsp_live & ~StallD & ~PCSrcE;
    load_buf = (state == S_HOLD) & ~StallD & ~PCSrcE;
    capture  = rsp_live & StallD & ~PCSrcE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcf    <= RESET_PC;
      req_pc <= '0;
      kill   <= 1'b0;
    end else begin
      if (PCSrcE)     pcf <= redirect_pc;
      else if (grant) pcf <= pcf + XLEN'(4);
      if (grant) req_pc <= pcf;
      // A redirect while the response is still in flight marks it stale.
      if (rsp && kill)                                         kill <= 1'b0;
      else if ((state == S_WAIT) && !imem_rvalid && PCSrcE) kill <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_instr <= '0;
      buf_pc    <= '0;
    end else if (capture) begin
      buf_instr <= imem_rdata;
      buf_pc    <= req_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      if (load_mem) begin
        InstrD   <= imem_rdata;
        PCD      <= req_pc;
        PCPlus4D <= req_pc + XLEN'(4);
        ValidD   <= 1'b1;
      end else if (load_buf) begin
        InstrD   <= buf_instr;
        PCD      <= buf_pc;
        PCPlus4D <= buf_pc + XLEN'(4);
        ValidD   <= 1'b1;
      end else begin
        // Bubble keeps the previous PC fields.
        InstrD <= NOP_INSTR;
        ValidD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: a memory model answers grants with data
// addr|0x13, the stimulus side pushes the expected program-order PC stream
// (restarted at every redirect or reset) and a monitor compares every
// instruction entering decode against that stream.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0, reset = 1'b0;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
  logic        PCSrcE = 1'b0, PCJalSrcE = 1'b0;
  logic [31:0] PCTargetE = '0, ALUResultE = '0;
  logic        imem_req, imem_gnt = 1'b1, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCJalSrcE(PCJalSrcE), .PCTargetE(PCTargetE),
    .ALUResultE(ALUResultE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  int vectors = 0, miscompares = 0, loads = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected decode stream: sequential PCs from the start address.
  task automatic new_stream(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 1024; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // ---------------- memory model ----------------
  int          mem_lat = 1;
  bit          mem_rand = 1'b0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          cnt = 0;

  initial forever begin
    @(posedge clk); #2;
    if (pend && cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend_addr | 32'h13;
      pend        = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pend) cnt--;
    end
    @(negedge clk);
    if (imem_req && imem_gnt) begin
      check("one_outstanding", 32'(pend), 32'd0);
      pend      = 1'b1;
      pend_addr = imem_addr;
      cnt       = mem_rand ? int'($urandom_range(0, 3)) : mem_lat - 1;
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    logic [31:0] e;
    @(posedge clk); #1;
    if (reset) begin
      if (FlushD) begin
        check("flush_validd", 32'(ValidD), 32'd0);
      end else if (!StallD && ValidD) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard: unexpected instruction %h at pc %h", InstrD, PCD);
        end else begin
          vectors--;
          e = exp_q.pop_front();
          check("sb_InstrD", InstrD, e | 32'h13);
          check("sb_PCD", PCD, e);
          check("sb_PCPlus4D", PCPlus4D, e + 32'd4);
          loads++;
        end
      end
    end
  end

  // ---------------- bounded waits ----------------
  task automatic wait_req(input int max, input string name);
    int n = 0;
    do begin
      @(posedge clk); #2; @(negedge clk); n++;
    end while (!imem_req && n < max);
    vectors++;
    if (!imem_req) begin
      miscompares++;
      $display("FAIL %s: imem_req got 0 expected 1 within %0d cycles", name, max);
    end
  endtask

  task automatic wait_valid(input int max, input string name);
    int n = 0;
    do begin
      @(posedge clk); #2; @(negedge clk); n++;
    end while (!ValidD && n < max);
    vectors++;
    if (!ValidD) begin
      miscompares++;
      $display("FAIL %s: ValidD got 0 expected 1 within %0d cycles", name, max);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    new_stream(RESET_PC);
    @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_InstrD", InstrD, NOP);
    check("rst_PCD", PCD, 32'd0);
    check("rst_PCPlus4D", PCPlus4D, 32'd0);
    check("rst_ValidD", 32'(ValidD), 32'd0);
    @(posedge clk); #2; reset = 1'b1;

    // back-to-back zero-wait fetches
    @(negedge clk);
    check("seq_req0", 32'(imem_req), 32'd1);
    check("seq_addr0", imem_addr, 32'h0);
    @(posedge clk); #2; @(negedge clk);
    check("seq_addr1", imem_addr, 32'h4);
    @(posedge clk); #2; @(negedge clk);
    check("seq_addr2", imem_addr, 32'h8);
    check("seq_InstrD", InstrD, 32'h13);
    check("seq_PCD", PCD, 32'h0);
    check("seq_PCPlus4D", PCPlus4D, 32'h4);
    check("seq_ValidD", 32'(ValidD), 32'd1);

    // decode stall as the 0x8 response arrives
    @(posedge clk); #2; StallD = 1'b1;
    @(negedge clk);
    check("stall_req", 32'(imem_req), 32'd0);
    check("stall_PCD", PCD, 32'h4);
    repeat (2) begin
      @(posedge clk); #2; @(negedge clk);
      check("hold_req", 32'(imem_req), 32'd0);
      check("hold_PCD", PCD, 32'h4);
      check("hold_PCPlus4D", PCPlus4D, 32'h8);
    end
    @(posedge clk); #2; StallD = 1'b0;
    @(negedge clk);
    check("release_req", 32'(imem_req), 32'd0);
    @(posedge clk); #2; @(negedge clk);
    check("release_InstrD", InstrD, 32'h0000_001B);
    check("release_PCD", PCD, 32'h8);
    check("release_ValidD", 32'(ValidD), 32'd1);
    check("release_addr", imem_addr, 32'hC);

    // redirect while a latency-3 fetch of 0x10 is in flight
    @(posedge clk); #2; mem_lat = 3;
    @(negedge clk);
    check("pre_redir_addr", imem_addr, 32'h10);
    @(posedge clk); #2;
    PCSrcE = 1'b1; PCTargetE = 32'h100; FlushD = 1'b1; new_stream(32'h100);
    @(negedge clk);
    check("redir_req", 32'(imem_req), 32'd0);
    @(posedge clk); #2; PCSrcE = 1'b0; FlushD = 1'b0;
    @(negedge clk);
    wait_req(10, "redir_wait");
    check("redir_addr", imem_addr, 32'h100);
    check("redir_ValidD", 32'(ValidD), 32'd0);

    // jalr redirect clears bit 0 of the ALU result
    @(posedge clk); #2;
    PCSrcE = 1'b1; PCJalSrcE = 1'b1; ALUResultE = 32'h203; FlushD = 1'b1;
    new_stream(32'h202);
    @(posedge clk); #2;
    PCSrcE = 1'b0; PCJalSrcE = 1'b0; FlushD = 1'b0; mem_lat = 1;
    @(negedge clk);
    wait_req(10, "jalr_wait");
    check("jalr_addr", imem_addr, 32'h202);
    check("jalr_PCD_flushed", PCD, 32'h0);
    wait_valid(10, "jalr_valid");
    check("jalr_InstrD", InstrD, 32'h213);

    // flush and stall together: flush wins
    @(posedge clk); #2; FlushD = 1'b1; StallD = 1'b1;
    @(posedge clk); #2; FlushD = 1'b0; StallD = 1'b0; mem_lat = 4;
    @(negedge clk);
    check("flst_InstrD", InstrD, NOP);
    check("flst_ValidD", 32'(ValidD), 32'd0);
    check("flst_PCD", PCD, 32'h0);

    // reset while a request is outstanding
    wait_req(10, "pre_reset_wait");
    @(posedge clk); #2; reset = 1'b0; imem_gnt = 1'b0; new_stream(RESET_PC);
    @(negedge clk);
    check("mid_rst_req", 32'(imem_req), 32'd0);
    check("mid_rst_InstrD", InstrD, NOP);
    check("mid_rst_PCD", PCD, 32'h0);
    check("mid_rst_PCPlus4D", PCPlus4D, 32'h0);
    check("mid_rst_ValidD", 32'(ValidD), 32'd0);
    @(posedge clk); #2; reset = 1'b1;
    @(negedge clk);
    check("post_rst_req", 32'(imem_req), 32'd1);
    check("post_rst_addr", imem_addr, RESET_PC);
    repeat (2) begin @(posedge clk); #2; end
    @(negedge clk);
    check("late_rvalid_req", 32'(imem_req), 32'd1);
    check("late_rvalid_addr", imem_addr, RESET_PC);
    @(posedge clk); #2; imem_gnt = 1'b1; mem_lat = 1;
    @(negedge clk);
    check("late_rvalid_ignored", 32'(ValidD), 32'd0);
    wait_valid(10, "post_rst_valid");
    check("post_rst_PCD", PCD, RESET_PC);
    check("post_rst_PCPlus4D", PCPlus4D, RESET_PC + 32'd4);

    // randomized traffic
    mem_rand = 1'b1;
    repeat (3000) begin
      @(posedge clk); #2;
      imem_gnt   = ($urandom_range(0, 3) != 0);
      StallF     = ($urandom_range(0, 4) == 0);
      StallD     = ($urandom_range(0, 3) == 0);
      PCSrcE     = ($urandom_range(0, 24) == 0);
      FlushD     = PCSrcE;
      PCJalSrcE  = 1'($urandom_range(0, 1));
      PCTargetE  = 32'($urandom_range(0, 16383)) << 2;
      ALUResultE = $urandom;
      if (PCSrcE) new_stream(PCJalSrcE ? (ALUResultE & ~32'h1) : PCTargetE);
    end
    @(posedge clk); #2;
    PCSrcE = 1'b0; FlushD = 1'b0; StallD = 1'b0; StallF = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);

    vectors++;
    if (loads < 200) begin
      miscompares++;
      $display("FAIL throughput: got %0d decoded instructions expected at least 200", loads);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
